// File: rtl/job_dispatcher_if.sv
// Header-in and result-out word streams between the host path and job_dispatcher.
// Both streams: a word moves on a rising edge with valid && ready; the sender holds valid
// and data stable until that edge, and valid never waits on ready.
interface job_dispatcher_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_last
   );
endinterface

// File: rtl/job_dispatcher.sv
// Loads a 20-word block-header job, drives the mining supervisor through reset/run,
// captures its result and returns a 10-word result packet.
module job_dispatcher #(
   parameter int unsigned RESET_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   job_dispatcher_if.slave  bus,
   input  logic             abort,
   output logic             sup_reset,
   output logic             sup_start,
   output logic [31:0]      sup_version,
   output logic [31:0]      sup_timestamp,
   output logic [31:0]      sup_bits,
   output logic [31:0]      sup_target_bits,
   output logic [255:0]     sup_hash_prev,
   output logic [255:0]     sup_merkle_root,
   input  logic             sup_process_complete,
   input  logic             sup_success,
   input  logic [31:0]      sup_nonce_out,
   input  logic [255:0]     sup_hash_out,
   output logic             busy,
   output logic [15:0]      jobs_done,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      CAPTURE = 3'd3,
      SEND    = 3'd4
   } state_t;

   state_t         state_q;
   logic [4:0]     wi_q;
   logic [3:0]     ri_q;
   logic [7:0]     cnt_q;
   logic [31:0]    version_q;
   logic [31:0]    timestamp_q;
   logic [31:0]    bits_q;
   logic [31:0]    target_q;
   logic [255:0]   hash_prev_q;
   logic [255:0]   merkle_q;
   logic           success_q;
   logic [31:0]    nonce_q;
   logic [255:0]   hash_q;
   logic [15:0]    jobs_done_q;

   logic           out_fire;
   logic [2:0]     hp_sel;
   logic [2:0]     mr_sel;
   logic [2:0]     rw_sel;
   logic [255:0]   hash_d;
   logic [15:0]    jobs_done_d;
   logic [31:0]    out_data_d;

   assign out_fire    = bus.out_ready && (state_q == SEND);
   assign hp_sel      = 3'(wi_q - 5'd1);
   assign mr_sel      = 3'(wi_q - 5'd9);
   assign rw_sel      = 3'(ri_q - 4'd2);
   // On exhaustion the supervisor's hash is stale, so it is never let into the packet.
   assign hash_d      = sup_success ? sup_hash_out : '0;
   assign jobs_done_d = jobs_done_q + 16'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         wi_q        <= '0;
         ri_q        <= '0;
         cnt_q       <= '0;
         version_q   <= '0;
         timestamp_q <= '0;
         bits_q      <= '0;
         target_q    <= '0;
         hash_prev_q <= '0;
         merkle_q    <= '0;
         success_q   <= 1'b0;
         nonce_q     <= '0;
         hash_q      <= '0;
         jobs_done_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (abort) begin
                  wi_q <= '0;
               end else if (bus.in_valid) begin
                  case (wi_q)
                     5'd0:    version_q   <= bus.in_data;
                     5'd17:   timestamp_q <= bus.in_data;
                     5'd18:   bits_q      <= bus.in_data;
                     5'd19:   target_q    <= bus.in_data;
                     default: begin
                        if (wi_q <= 5'd8) hash_prev_q[{hp_sel, 5'b0} +: 32] <= bus.in_data;
                        else              merkle_q[{mr_sel, 5'b0} +: 32]    <= bus.in_data;
                     end
                  endcase
                  if (wi_q == 5'd19) begin
                     wi_q    <= '0;
                     cnt_q   <= 8'(RESET_CYCLES);
                     state_q <= CLEAR;
                  end else begin
                     wi_q <= wi_q + 5'd1;
                  end
               end
            end
            CLEAR: begin
               if (abort)               state_q <= IDLE;
               else if (cnt_q <= 8'd1)  state_q <= RUN;
               else                     cnt_q   <= cnt_q - 8'd1;
            end
            RUN: begin
               // Abort takes priority over a completion arriving on the same edge.
               if (abort) begin
                  state_q <= IDLE;
               end else if (sup_process_complete) begin
                  success_q <= sup_success;
                  nonce_q   <= sup_nonce_out;
                  hash_q    <= hash_d;
                  state_q   <= CAPTURE;
               end
            end
            CAPTURE: begin
               ri_q    <= '0;
               state_q <= SEND;
            end
            SEND: begin
               if (out_fire) begin
                  if (ri_q == 4'd9) begin
                     ri_q        <= '0;
                     jobs_done_q <= jobs_done_d;
                     state_q     <= IDLE;
                  end else begin
                     ri_q <= ri_q + 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      out_data_d = '0;
      if (state_q == SEND) begin
         if (ri_q == 4'd0)      out_data_d = {31'b0, success_q};
         else if (ri_q == 4'd1) out_data_d = nonce_q;
         else                   out_data_d = hash_q[{rw_sel, 5'b0} +: 32];
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == SEND);
   assign bus.out_data  = out_data_d;
   assign bus.out_last  = (state_q == SEND) && (ri_q == 4'd9);

   assign sup_reset = (state_q == IDLE) || (state_q == CLEAR) || (state_q == CAPTURE);
   assign sup_start = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   assign sup_version     = version_q;
   assign sup_timestamp   = timestamp_q;
   assign sup_bits        = bits_q;
   assign sup_target_bits = target_q;
   assign sup_hash_prev   = hash_prev_q;
   assign sup_merkle_root = merkle_q;
   assign jobs_done       = jobs_done_q;

endmodule

// File: doc/job_dispatcher.md
# job_dispatcher

Host-side initiator for the mining supervisor. It accepts a 20-word block-header job over a 32-bit valid/ready stream and registers the header fields. It then sequences the supervisor's reset/start controls, waits for completion, captures the result, and returns a 10-word result packet over a second valid/ready stream. It sits between the host register/DMA path and the supervisor, replacing direct config-register poking.

## Interface
Parameters:
- RESET_CYCLES, default 2: cycles supervisor reset is held after a job loads; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  header word valid
- in_ready  out  1  header word accepted when in_valid && in_ready
- in_data  in  32  header word
- abort  in  1  cancel current job
- out_valid  out  1  result word valid
- out_ready  in  1  result consumer ready
- out_data  out  32  result word
- out_last  out  1  high on final result word (index 9)
- sup_reset  out  1  to supervisor reset
- sup_start  out  1  to supervisor start
- sup_version / sup_timestamp / sup_bits / sup_target_bits  out  32 each  registered header fields
- sup_hash_prev / sup_merkle_root  out  256 each  registered header fields
- sup_process_complete  in  1  from supervisor
- sup_success  in  1  from supervisor
- sup_nonce_out  in  32  from supervisor
- sup_hash_out  in  256  from supervisor
- busy  out  1  state != IDLE
- jobs_done  out  16  completed-packet counter; wraps 0xFFFF -> 0

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE, SEND.
- Supervisor controls decode directly from the state register:
  - sup_reset = 1 in IDLE, CLEAR and CAPTURE; 0 otherwise.
  - sup_start = 1 only in RUN.
- IDLE:
  - in_ready = 1; 5-bit word index wi counts 0..19.
  - Word mapping: wi 0 version; 1..8 hash_prev, LSW first (wi 1 -> bits [31:0]); 9..16 merkle_root, LSW first; 17 timestamp; 18 bits; 19 target_bits.
  - Each field register updates on its accepted word.
  - Acceptance of wi=19 -> CLEAR, wi -> 0.
- CLEAR: down-counter loaded with RESET_CYCLES; -> RUN when it expires.
- RUN: sup_process_complete sampled each cycle; high -> CAPTURE, latching sup_success, sup_nonce_out and sup_hash_out on that edge.
- CAPTURE: one cycle -> SEND; word index ri = 0.
- SEND, result words by ri:
  - 0: {31'b0, success}
  - 1: nonce
  - 2..9: hash, LSW first; all zero when success = 0 (supervisor hash is stale on exhaustion)
- SEND handshake:
  - out_valid = 1 throughout SEND.
  - out_data/out_last held stable while out_valid && !out_ready.
  - ri advances on handshake.
  - Handshake at ri = 9 -> IDLE and jobs_done + 1 on the same edge.
- abort:
  - In CLEAR/RUN: -> IDLE next edge, no packet, jobs_done unchanged. Abort wins over a simultaneous sup_process_complete.
  - In IDLE: wi -> 0; a partial header is discarded, field registers keep their values.
  - In CAPTURE/SEND: ignored; the packet completes.
- Header fields are never modified outside IDLE.
- Reset (async, any state) forces:
  - state IDLE; wi, ri and counters 0; all field registers 0; jobs_done 0.
  - in_ready 1, sup_reset 1, sup_start 0, out_valid 0, out_data 0, out_last 0, busy 0.

## Timing
- Last header word accepted at edge N:
  - CLEAR covers cycles N+1 .. N+RESET_CYCLES.
  - RUN starts at N+RESET_CYCLES+1; first cycle with sup_reset = 0 and sup_start = 1.
- sup_process_complete high in cycle M: CAPTURE in M+1, first result word valid in M+2.
- Minimum packet duration 10 cycles with out_ready held high.
- Back-to-back jobs: in_ready rises the cycle after the final result handshake.
- in_ready is low during CLEAR, RUN, CAPTURE and SEND; no words are accepted or buffered then.

## Test plan
- Reset:
  - Assert reset_n = 0 mid-RUN -> sup_start 0, sup_reset 1 immediately (asynchronous).
  - After release: in_ready 1, out_valid 0, jobs_done 0.
- Successful job:
  - Stimulus: version 0x20000000, hash_prev words 0x11111111..0x88888888, RESET_CYCLES = 2; behavioural supervisor raises complete after 100 cycles with success 1, nonce 0x1234ABCD.
  - Required: sup_hash_prev[31:0] = 0x11111111; sup_reset low exactly 3 cycles after the last accept.
  - Required: packet 0x00000001, 0x1234ABCD, then hash LSW first; out_last only on word 9; jobs_done = 1.
- Exhaustion: success 0, nonce 0xFFFFFFFF -> packet 0x00000000, 0xFFFFFFFF, then eight 0x00000000 words.
- Backpressure: out_ready low for 5 cycles on word 3 and random thereafter -> data stable while stalled; exactly 10 words, no duplication.
- Abort:
  - Abort coincident with sup_process_complete -> IDLE, no out_valid, jobs_done unchanged.
  - Abort after 7 header words, then a full 20-word job -> fields decode from wi = 0.
- Counter wrap: preload via 65536 short jobs (or a forced counter value) -> jobs_done 0xFFFF -> 0x0000.
